// File: rtl/arf_rat_pkg.sv
// arf_rat_pkg: shared widths and types for the architectural register file and rename table
package arf_rat_pkg;
  localparam int N_ARF_REGS = 32;
  localparam int ARF_ID_WIDTH = $clog2(N_ARF_REGS);
  localparam int ROB_N_ENTRIES = 64;
  localparam int ROB_ID_WIDTH = $clog2(ROB_N_ENTRIES);
  localparam int REG_DATA_WIDTH = 32;
  typedef logic [ARF_ID_WIDTH-1:0] arf_id_t;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef struct packed {
    logic renamed;
    rob_id_t rob_id;
  } rat_entry_t;
endpackage

// File: rtl/arf_rat_entry.sv
// arf_rat_entry: one architectural register plus its rename mapping
module arf_rat_entry
  import arf_rat_pkg::*;
(
  input  logic       clk,
  input  logic       rst_aL,
  input  logic       dispatch_we,
  input  logic       retire_we,
  input  logic       flush,
  input  rob_id_t    dispatch_rob_id,
  input  rob_id_t    retire_rob_id,
  input  reg_data_t  retire_reg_data,
  output reg_data_t  data,
  output rat_entry_t rat
);
  // Flush beats dispatch, dispatch beats the retire release so a younger mapping survives.
  always_ff @(posedge clk or negedge rst_aL)
    if (!rst_aL) begin
      data <= '0;
      rat <= '0;
    end else begin
      if (retire_we) data <= retire_reg_data;
      if (flush) rat <= '0;
      else if (dispatch_we) rat <= {1'b1, dispatch_rob_id};
      else if (retire_we && rat.rob_id == retire_rob_id) rat <= '0;
    end
endmodule

// File: rtl/arf_rat.sv
// arf_rat: architectural register file with register alias table, two lookups with retire bypass
module arf_rat
  import arf_rat_pkg::*;
(
  input  logic      clk,
  input  logic      rst_aL,
  input  logic      dispatch_fire,
  input  logic      dispatch_dst_valid,
  input  arf_id_t   dispatch_dst_arf_id,
  input  rob_id_t   dispatch_rob_id,
  input  arf_id_t   src1_arf_id,
  output logic      src1_renamed,
  output rob_id_t   src1_rob_id,
  output reg_data_t src1_arf_data,
  input  arf_id_t   src2_arf_id,
  output logic      src2_renamed,
  output rob_id_t   src2_rob_id,
  output reg_data_t src2_arf_data,
  input  logic      retire,
  input  rob_id_t   retire_rob_id,
  input  arf_id_t   retire_arf_id,
  input  reg_data_t retire_reg_data,
  input  logic      flush
);
  reg_data_t  data_q [N_ARF_REGS];
  rat_entry_t rat_q [N_ARF_REGS];
  rat_entry_t e1, e2;
  logic       b1, b2;
  assign data_q[0] = '0;
  assign rat_q[0] = '0;
  for (genvar g = 1; g < N_ARF_REGS; g++) begin : g_reg
    arf_rat_entry u_entry (
      .clk             (clk),
      .rst_aL          (rst_aL),
      .dispatch_we     (dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id == arf_id_t'(g)),
      .retire_we       (retire && retire_arf_id == arf_id_t'(g)),
      .flush           (flush),
      .dispatch_rob_id (dispatch_rob_id),
      .retire_rob_id   (retire_rob_id),
      .retire_reg_data (retire_reg_data),
      .data            (data_q[g]),
      .rat             (rat_q[g])
    );
  end
  // The producer retiring this cycle is leaving the ROB, so forward its value instead.
  assign e1 = rat_q[src1_arf_id];
  assign e2 = rat_q[src2_arf_id];
  assign b1 = retire && retire_arf_id == src1_arf_id && e1.renamed && e1.rob_id == retire_rob_id;
  assign b2 = retire && retire_arf_id == src2_arf_id && e2.renamed && e2.rob_id == retire_rob_id;
  assign src1_renamed = e1.renamed && !b1;
  assign src2_renamed = e2.renamed && !b2;
  assign src1_rob_id = src1_renamed ? e1.rob_id : '0;
  assign src2_rob_id = src2_renamed ? e2.rob_id : '0;
  assign src1_arf_data = b1 ? retire_reg_data : data_q[src1_arf_id];
  assign src2_arf_data = b2 ? retire_reg_data : data_q[src2_arf_id];
endmodule

// File: tb/tb_arf_rat.sv
// tb_arf_rat: scoreboard bench for arf_rat against a behavioural reference model
module tb_arf_rat;
  import arf_rat_pkg::*;
  logic clk = 0, rst_aL = 0;
  logic dispatch_fire = 0, dispatch_dst_valid = 0, retire = 0, flush = 0;
  arf_id_t dispatch_dst_arf_id = '0, src1_arf_id = '0, src2_arf_id = '0, retire_arf_id = '0;
  rob_id_t dispatch_rob_id = '0, retire_rob_id = '0, src1_rob_id, src2_rob_id;
  reg_data_t retire_reg_data = '0, src1_arf_data, src2_arf_data;
  logic src1_renamed, src2_renamed;
  int n_checks = 0, n_fail = 0;
  reg_data_t m_data [N_ARF_REGS];
  logic      m_ren [N_ARF_REGS];
  rob_id_t   m_rob [N_ARF_REGS];
  typedef struct {
    string tag;
    logic r1, r2;
    rob_id_t o1, o2;
    reg_data_t d1, d2;
  } exp_t;
  exp_t sb [$];

  arf_rat dut (
    .clk(clk), .rst_aL(rst_aL),
    .dispatch_fire(dispatch_fire), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src1_renamed(src1_renamed), .src1_rob_id(src1_rob_id), .src1_arf_data(src1_arf_data),
    .src2_arf_id(src2_arf_id), .src2_renamed(src2_renamed), .src2_rob_id(src2_rob_id), .src2_arf_data(src2_arf_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_ARF_REGS; i++) begin
      m_data[i] = '0;
      m_ren[i] = 0;
      m_rob[i] = '0;
    end
  endtask

  task automatic model_read(input arf_id_t a, output logic r, output rob_id_t o, output reg_data_t d);
    logic byp;
    byp = retire && retire_arf_id == a && m_ren[a] && m_rob[a] == retire_rob_id;
    r = (a != 0) && m_ren[a] && !byp;
    o = r ? m_rob[a] : '0;
    d = (a == 0) ? '0 : byp ? retire_reg_data : m_data[a];
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    model_read(src1_arf_id, e.r1, e.o1, e.d1);
    model_read(src2_arf_id, e.r2, e.o2, e.d2);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_r1"}, 32'(src1_renamed), 32'(e.r1));
    check({e.tag, "_o1"}, 32'(src1_rob_id), 32'(e.o1));
    check({e.tag, "_d1"}, src1_arf_data, e.d1);
    check({e.tag, "_r2"}, 32'(src2_renamed), 32'(e.r2));
    check({e.tag, "_o2"}, 32'(src2_rob_id), 32'(e.o2));
    check({e.tag, "_d2"}, src2_arf_data, e.d2);
  endtask

  task automatic model_update();
    if (retire && retire_arf_id != 0) begin
      m_data[retire_arf_id] = retire_reg_data;
      if (m_rob[retire_arf_id] == retire_rob_id) begin
        m_ren[retire_arf_id] = 0;
        m_rob[retire_arf_id] = '0;
      end
    end
    if (flush) for (int i = 0; i < N_ARF_REGS; i++) begin
      m_ren[i] = 0;
      m_rob[i] = '0;
    end
    else if (dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id != 0) begin
      m_ren[dispatch_dst_arf_id] = 1;
      m_rob[dispatch_dst_arf_id] = dispatch_rob_id;
    end
  endtask

  task automatic step(input string tag, input logic df, input arf_id_t dd, input rob_id_t dr,
                      input arf_id_t s1, input arf_id_t s2, input logic rt, input rob_id_t rr,
                      input arf_id_t ra, input reg_data_t rd, input logic fl);
    dispatch_fire = df;
    dispatch_dst_valid = df;
    dispatch_dst_arf_id = dd;
    dispatch_rob_id = dr;
    src1_arf_id = s1;
    src2_arf_id = s2;
    retire = rt;
    retire_rob_id = rr;
    retire_arf_id = ra;
    retire_reg_data = rd;
    flush = fl;
    push_exp(tag);
    @(negedge clk);
    pop_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    #12;
    rst_aL = 1;
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 5, 31, 0, 0, 0, 0, 0);
    step("disp3", 1, 3, 7, 3, 0, 0, 0, 0, 0, 0);
    step("look3", 0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    step("ret_byp", 0, 0, 0, 3, 0, 1, 7, 3, 32'hDEADBEEF, 0);
    step("ret_after", 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    step("disp3b", 1, 3, 9, 3, 0, 0, 0, 0, 0, 0);
    step("ret_stale", 0, 0, 0, 3, 0, 1, 7, 3, 32'h11, 0);
    step("stale_after", 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    step("disp4", 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("coll4", 1, 4, 2, 4, 4, 1, 1, 4, 32'h44, 0);
    step("coll4_after", 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    step("disp0", 1, 0, 5, 0, 0, 1, 0, 0, 32'hFF, 0);
    step("reg0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("disp1", 1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    step("disp2", 1, 2, 11, 1, 2, 0, 0, 0, 0, 0);
    step("flush", 1, 5, 4, 1, 5, 1, 10, 1, 32'h55, 1);
    step("flush_a", 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    step("flush_b", 0, 0, 0, 2, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      arf_id_t ra;
      rob_id_t rr;
      ra = arf_id_t'($urandom_range(0, 7));
      rr = ($urandom_range(0, 1) == 1) ? m_rob[ra] : rob_id_t'($urandom);
      step("rand", $urandom_range(0, 2) != 0, arf_id_t'($urandom_range(0, 7)), rob_id_t'($urandom),
           arf_id_t'($urandom_range(0, 7)), arf_id_t'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, rr, ra, $urandom, $urandom_range(0, 19) == 0);
    end
    step("pre_rst", 1, 6, 33, 6, 4, 1, 0, 4, 32'hABCD, 0);
    dispatch_fire = 0;
    dispatch_dst_valid = 0;
    retire = 0;
    flush = 0;
    src1_arf_id = 6;
    src2_arf_id = 4;
    #2;
    rst_aL = 0;
    #1;
    model_clear();
    push_exp("mid_rst");
    pop_check();
    @(posedge clk);
    #1;
    rst_aL = 1;
    step("post_rst", 0, 0, 0, 6, 4, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
